// File: rtl/counter_cmd_sequencer.sv
// Command sequencer that turns LOAD/CLEAR/RUN/NOP commands into load, clear and
// enable strobes for a downstream load/clear/enable counter, with hold and abort.
module counter_cmd_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_arg,
    input  logic             hold,
    input  logic             abort,
    output logic             cnt_load,
    output logic [WIDTH-1:0] cnt_load_value,
    output logic             cnt_clr,
    output logic             cnt_ena,
    output logic             busy,
    output logic [WIDTH-1:0] run_left,
    output logic             done,
    output logic             done_aborted
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACT  = 2'd1,
        RUN  = 2'd2,
        FIN  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_LOAD  = 2'b01,
        OP_CLEAR = 2'b10,
        OP_RUN   = 2'b11
    } op_t;

    state_t           state;
    op_t              op_q;
    logic [WIDTH-1:0] arg_q;

    // Strobes decode the registered state; rst forces them low in the same cycle.
    assign cmd_ready      = (state == IDLE) && !rst;
    assign busy           = (state != IDLE) && !rst;
    assign done           = (state == FIN)  && !rst;
    assign cnt_load       = (state == ACT) && (op_q == OP_LOAD)  && !rst;
    assign cnt_clr        = (state == ACT) && (op_q == OP_CLEAR) && !rst;
    assign cnt_ena        = (state == RUN) && !hold && !abort && !rst;
    assign cnt_load_value = arg_q;

    // NOTE: all state updates use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            op_q         <= OP_NOP;
            arg_q        <= '0;
            run_left     <= '0;
            done_aborted <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q         <= op_t'(cmd_op);
                        arg_q        <= cmd_arg;
                        done_aborted <= 1'b0;
                        case (op_t'(cmd_op))
                            OP_LOAD, OP_CLEAR: state <= ACT;
                            OP_RUN: begin
                                if (cmd_arg == '0) begin
                                    state <= FIN;
                                end else begin
                                    state    <= RUN;
                                    run_left <= cmd_arg;
                                end
                            end
                            default: state <= FIN;
                        endcase
                    end
                end
                ACT: state <= FIN;
                RUN: begin
                    if (abort) begin
                        done_aborted <= 1'b1;
                        state        <= FIN;
                    end else if (!hold) begin
                        // Guarded decrement keeps run_left from wrapping below zero.
                        if (run_left != '0) begin
                            run_left <= run_left - 1'b1;
                        end
                        if (run_left <= 1) begin
                            state <= FIN;
                        end
                    end
                end
                FIN: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_counter_cmd_sequencer.sv
// Randomized bench for counter_cmd_sequencer: transaction-level expectations
// plus a shadow counter driven by the DUT strobes.
module tb_counter_cmd_sequencer;

    localparam int WIDTH = 8;
    localparam logic [1:0] NOP = 2'b00, LOAD = 2'b01, CLEAR = 2'b10, RUN = 2'b11;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_arg;
    logic             hold;
    logic             abort;
    logic             cnt_load;
    logic [WIDTH-1:0] cnt_load_value;
    logic             cnt_clr;
    logic             cnt_ena;
    logic             busy;
    logic [WIDTH-1:0] run_left;
    logic             done;
    logic             done_aborted;

    int total = 0;
    int bad   = 0;
    int strobe_overlap = 0;

    logic [WIDTH-1:0] shadow  = '0;
    logic [WIDTH-1:0] exp_cnt = '0;

    counter_cmd_sequencer #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_arg(cmd_arg), .hold(hold), .abort(abort),
        .cnt_load(cnt_load), .cnt_load_value(cnt_load_value), .cnt_clr(cnt_clr),
        .cnt_ena(cnt_ena), .busy(busy), .run_left(run_left), .done(done),
        .done_aborted(done_aborted)
    );

    always #5 clk = ~clk;

    // Counter fed by the strobes, as the downstream block would see them.
    always @(posedge clk) begin
        if (cnt_load && cnt_clr) strobe_overlap <= strobe_overlap + 1;
        if (cnt_clr)       shadow <= '0;
        else if (cnt_load) shadow <= cnt_load_value;
        else if (cnt_ena)  shadow <= shadow + 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [WIDTH-1:0] arg,
                           input int abort_at, input int hold_pct,
                           input int hold_after, input int hold_len);
        int  ena_cnt = 0, holds = 0, held = 0, cycles = 0;
        bit  aborted = 0, fin = 0, forced;
        logic h, a;
        @(negedge clk);
        hold = 1'($urandom); abort = 1'($urandom);
        #1;
        check("idle_ready", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_arg = WIDTH'($urandom);
        if (op == LOAD || op == CLEAR) begin
            hold = 1'($urandom); abort = 1'($urandom);
            #1;
            check("act_load", cnt_load, op == LOAD);
            check("act_clr",  cnt_clr,  op == CLEAR);
            check("act_ena",  cnt_ena,  0);
            check("act_done", done,     0);
            if (op == LOAD) check("act_value", cnt_load_value, arg);
            @(negedge clk);
        end else if (op == RUN && arg != 0) begin
            while (!fin && cycles < 1000) begin
                forced = (ena_cnt == hold_after) && (held < hold_len);
                if (forced) held++;
                a = (abort_at >= 0) && (ena_cnt == abort_at);
                h = forced || ($urandom_range(99) < hold_pct);
                hold = h; abort = a;
                #1;
                check("run_left", run_left, 32'(arg) - ena_cnt);
                check("run_ena",  cnt_ena,  !h && !a);
                check("run_done", done, 0);
                if (a) begin aborted = 1; fin = 1; end
                else if (h) holds++;
                else begin ena_cnt++; if (ena_cnt == arg) fin = 1; end
                @(negedge clk);
                cycles++;
            end
            if (!fin) check("run_timeout", 0, 1);
        end
        hold = 1'($urandom); abort = 1'($urandom);
        #1;
        check("fin_done",    done, 1);
        check("fin_busy",    busy, 1);
        check("fin_ready",   cmd_ready, 0);
        check("fin_aborted", done_aborted, aborted);
        check("fin_strobes", {cnt_load, cnt_clr, cnt_ena}, 0);
        if (op == RUN && arg != 0)
            check("fin_run_left", run_left, aborted ? 32'(arg) - ena_cnt : 0);
        case (op)
            LOAD:    exp_cnt = arg;
            CLEAR:   exp_cnt = '0;
            RUN:     exp_cnt = exp_cnt + WIDTH'(ena_cnt);
            default: ;
        endcase
        @(negedge clk);
        #1;
        check("post_ready",   cmd_ready, 1);
        check("post_done",    done, 0);
        check("post_busy",    busy, 0);
        check("post_aborted", done_aborted, aborted);
        check("post_value",   cnt_load_value, arg);
        check("counter",      shadow, exp_cnt);
    endtask

    initial begin
        int loads, xfers, first, second;
        logic [WIDTH-1:0] vals [2];
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = NOP; cmd_arg = '0; hold = 0; abort = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        #1;
        check("rst_ready", cmd_ready, 0);
        check("rst_outs",  {cnt_load, cnt_clr, cnt_ena, busy, done}, 0);
        @(negedge clk);
        cmd_valid = 1'b0; rst = 1'b0;
        #1;
        check("rst_run_left", run_left, 0);
        check("rst_value",    cnt_load_value, 0);
        check("rst_aborted",  done_aborted, 0);
        check("rst_ready_up", cmd_ready, 1);

        // Directed plan items
        run_cmd(LOAD, 8'hA5, -1, 0, -1, 0);
        run_cmd(RUN,  8'd5,  -1, 0, -1, 0);
        run_cmd(RUN,  8'd4,  -1, 0,  2, 3);
        run_cmd(RUN,  8'd200, 10, 0, -1, 0);
        run_cmd(RUN,  8'd0,  -1, 0, -1, 0);
        run_cmd(NOP,  8'h3C, -1, 0, -1, 0);
        run_cmd(CLEAR, 8'h77, -1, 0, -1, 0);

        // Reset in the middle of RUN 50 after 7 enables
        @(negedge clk);
        hold = 0; abort = 0;
        cmd_valid = 1'b1; cmd_op = RUN; cmd_arg = 8'd50;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            #1;
            check("mid_ena", cnt_ena, 1);
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        check("mid_rst_outs", {cmd_ready, cnt_load, cnt_clr, cnt_ena, busy, done}, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        exp_cnt = exp_cnt + 8'd7;
        check("mid_busy",     busy, 0);
        check("mid_done",     done, 0);
        check("mid_run_left", run_left, 0);
        check("mid_ready",    cmd_ready, 1);
        check("mid_value",    cnt_load_value, 0);
        check("mid_counter",  shadow, exp_cnt);

        // Command held valid while busy is taken exactly once
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = LOAD; cmd_arg = 8'h11;
        loads = 0; xfers = 0; first = -1; second = -1;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (cnt_load) begin
                if (loads < 2) vals[loads] = cnt_load_value;
                loads++;
            end
            if (cmd_valid && cmd_ready) begin
                xfers++;
                if (xfers == 1) first = c; else second = c;
            end
            @(negedge clk);
            if (xfers == 1) cmd_arg = 8'h22;
            if (xfers >= 2) cmd_valid = 1'b0;
        end
        check("fc_loads", loads, 2);
        check("fc_xfers", xfers, 2);
        check("fc_gap",   second - first, 3);
        check("fc_val0",  vals[0], 8'h11);
        check("fc_val1",  vals[1], 8'h22);
        exp_cnt = 8'h22;
        check("fc_counter", shadow, exp_cnt);

        // Randomized commands
        for (int i = 0; i < 60; i++) begin
            logic [1:0]       op;
            logic [WIDTH-1:0] arg;
            int               ab;
            op  = 2'($urandom);
            arg = (op == RUN) ? WIDTH'($urandom_range(12)) : WIDTH'($urandom);
            ab  = -1;
            if (op == RUN && arg != 0 && $urandom_range(3) == 0)
                ab = $urandom_range(int'(arg) - 1);
            run_cmd(op, arg, ab, $urandom_range(40), -1, 0);
        end

        check("strobe_overlap", strobe_overlap, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
